// File: rtl/stream_demux.sv
// Registered 1-to-NUM_CH stream demultiplexer with unicast/broadcast routing,
// a 2-entry FIFO per output channel and a saturating count of dropped beats.
module stream_demux #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_bcast,
  input  logic [DATA_W-1:0]        in_data,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int SEL_N = 2**SEL_W;
  localparam logic [SEL_W:0] NUM_CH_V = (SEL_W+1)'(NUM_CH);

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [SEL_N-1:0]  full_sel;
  logic              sel_ok;
  logic              accept;
  logic [CNT_W-1:0]  drop_cnt_reg;

  assign sel_ok = ({1'b0, in_sel} < NUM_CH_V);

  // Select indices beyond NUM_CH map to "never full" so they always drain.
  genvar gi;
  generate
    for (gi = 0; gi < SEL_N; gi++) begin : g_full_sel
      if (gi < NUM_CH) begin : g_real
        assign full_sel[gi] = full[gi];
      end else begin : g_pad
        assign full_sel[gi] = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    in_ready = 1'b0;
    if (!rst_n)
      in_ready = 1'b0;
    else if (in_bcast)
      in_ready = ~|full;
    else if (sel_ok)
      in_ready = ~full_sel[in_sel];
    else
      in_ready = 1'b1;
  end

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_cnt_reg <= '0;
    else if (accept && !in_bcast && !sel_ok && (drop_cnt_reg != {CNT_W{1'b1}}))
      drop_cnt_reg <= drop_cnt_reg + 1'b1;
  end

  assign drop_cnt = drop_cnt_reg;

  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DATA_W-1:0] mem_reg [2];
      logic              wr_ptr_reg;
      logic              rd_ptr_reg;
      logic [1:0]        count_reg;

      assign full[gi]      = (count_reg == 2'd2);
      assign out_valid[gi] = (count_reg != 2'd0);
      assign out_data[gi*DATA_W +: DATA_W] = mem_reg[rd_ptr_reg];
      assign push[gi] = accept & (in_bcast | (sel_ok & (in_sel == SEL_W'(gi))));
      assign pop[gi]  = out_valid[gi] & out_ready[gi];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mem_reg[0] <= '0;
          mem_reg[1] <= '0;
          wr_ptr_reg <= 1'b0;
          rd_ptr_reg <= 1'b0;
          count_reg  <= 2'd0;
        end else begin
          if (push[gi]) begin
            mem_reg[wr_ptr_reg] <= in_data;
            wr_ptr_reg          <= ~wr_ptr_reg;
          end
          if (pop[gi])
            rd_ptr_reg <= ~rd_ptr_reg;
          case ({push[gi], pop[gi]})
            2'b10:   count_reg <= count_reg + 2'd1;
            2'b01:   count_reg <= count_reg - 2'd1;
            default: count_reg <= count_reg;
          endcase
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: a 4-channel instance for routing, backpressure,
// broadcast, throughput and reset, and a 3-channel instance for drop counting.
module tb_stream_demux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sel;
  logic        in_bcast;
  logic [7:0]  in_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data;
  logic [7:0]  drop_cnt;

  logic        in_valid3;
  logic        in_ready3;
  logic [2:0]  out_valid3;
  logic [2:0]  out_ready3;
  logic [23:0] out_data3;
  logic [1:0]  drop_cnt3;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  stream_demux #(.DATA_W(8), .NUM_CH(4), .SEL_W(2), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_bcast(in_bcast), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .drop_cnt(drop_cnt)
  );

  stream_demux #(.DATA_W(8), .NUM_CH(3), .SEL_W(2), .CNT_W(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_sel(in_sel), .in_bcast(in_bcast), .in_data(in_data),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .drop_cnt(drop_cnt3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock step; inputs are sampled at the edge, outputs read 1 ns after it.
  task automatic cycle();
    if (in_valid && in_ready)
      $display("t=%0t beat dut4 sel=%0d bcast=%0d data=%02h", $time, in_sel, in_bcast, in_data);
    if (in_valid3 && in_ready3)
      $display("t=%0t beat dut3 sel=%0d bcast=%0d data=%02h", $time, in_sel, in_bcast, in_data);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic b, input logic [7:0] d);
    in_valid = v;
    in_sel   = s;
    in_bcast = b;
    in_data  = d;
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_sel     = 2'd0;
    in_bcast   = 1'b0;
    in_data    = 8'h00;
    out_ready  = 4'h0;
    in_valid3  = 1'b0;
    out_ready3 = 3'h0;
    #1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
    chk("reset_out_valid", {28'd0, out_valid}, 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    #21;
    rst_n = 1'b1;
    cycle();

    // Unicast sweep, all consumers ready.
    out_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), 1'b0, 8'hA0 + 8'(i));
      chk("sweep_in_ready", {31'd0, in_ready}, 32'd1);
      cycle();
      chk("sweep_out_valid", {28'd0, out_valid}, 32'd1 << i);
      chk("sweep_data", {24'd0, out_data[i*8 +: 8]}, {24'd0, 8'hA0 + 8'(i)});
    end
    drive(1'b0, 2'd0, 1'b0, 8'h00);
    cycle();
    chk("sweep_drain", {28'd0, out_valid}, 32'd0);

    // Backpressure on channel 1.
    out_ready = 4'b1101;
    drive(1'b1, 2'd1, 1'b0, 8'h11);
    chk("bp_rdy_1st", {31'd0, in_ready}, 32'd1);
    cycle();
    drive(1'b1, 2'd1, 1'b0, 8'h22);
    chk("bp_rdy_2nd", {31'd0, in_ready}, 32'd1);
    cycle();
    drive(1'b1, 2'd1, 1'b0, 8'h33);
    chk("bp_rdy_3rd", {31'd0, in_ready}, 32'd0);
    chk("bp_head_11", {24'd0, out_data[15:8]}, 32'h11);
    cycle();
    chk("bp_hold_valid", {28'd0, out_valid}, 32'b0010);
    chk("bp_hold_11", {24'd0, out_data[15:8]}, 32'h11);
    out_ready = 4'hF;
    #1;
    chk("bp_rdy_not_from_out_ready", {31'd0, in_ready}, 32'd0);
    cycle();
    chk("bp_head_22", {24'd0, out_data[15:8]}, 32'h22);
    chk("bp_rdy_after_pop", {31'd0, in_ready}, 32'd1);
    cycle();
    chk("bp_head_33", {24'd0, out_data[15:8]}, 32'h33);
    chk("bp_valid_33", {28'd0, out_valid}, 32'b0010);
    drive(1'b0, 2'd0, 1'b0, 8'h00);
    cycle();
    chk("bp_drain", {28'd0, out_valid}, 32'd0);

    // Broadcast blocked by a full channel 3.
    out_ready = 4'b0111;
    drive(1'b1, 2'd3, 1'b0, 8'hC1);
    cycle();
    drive(1'b1, 2'd3, 1'b0, 8'hC2);
    cycle();
    drive(1'b1, 2'd0, 1'b1, 8'h5A);
    chk("bc_blocked", {31'd0, in_ready}, 32'd0);
    cycle();
    chk("bc_still_blocked", {31'd0, in_ready}, 32'd0);
    chk("bc_ch3_only", {28'd0, out_valid}, 32'b1000);
    out_ready = 4'hF;
    #1;
    chk("bc_blocked_ready_hi", {31'd0, in_ready}, 32'd0);
    cycle();
    chk("bc_ch3_head_c2", {24'd0, out_data[31:24]}, 32'hC2);
    chk("bc_unblocked", {31'd0, in_ready}, 32'd1);
    cycle();
    drive(1'b0, 2'd0, 1'b0, 8'h00);
    chk("bc_all_valid", {28'd0, out_valid}, 32'hF);
    chk("bc_all_data", out_data, 32'h5A5A5A5A);
    cycle();
    chk("bc_drain", {28'd0, out_valid}, 32'd0);

    // Out-of-range drop on the 3-channel instance.
    drive(1'b0, 2'd3, 1'b0, 8'hE0);
    in_valid3 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      in_data = 8'hE0 + 8'(k);
      #1;
      chk("drop_in_ready", {31'd0, in_ready3}, 32'd1);
      cycle();
      chk("drop_cnt", {30'd0, drop_cnt3}, (k < 3) ? k : 3);
      chk("drop_no_valid", {29'd0, out_valid3}, 32'd0);
    end
    in_valid3 = 1'b0;
    chk("drop_main_cnt", {24'd0, drop_cnt}, 32'd0);

    // Streaming throughput on channel 0.
    out_ready = 4'b0001;
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 2'd0, 1'b0, 8'h40 + 8'(k));
      chk("tp_in_ready", {31'd0, in_ready}, 32'd1);
      cycle();
      chk("tp_valid", {28'd0, out_valid}, 32'b0001);
      chk("tp_data", {24'd0, out_data[7:0]}, {24'd0, 8'h40 + 8'(k)});
    end
    drive(1'b0, 2'd0, 1'b0, 8'h00);
    cycle();
    chk("tp_drain", {28'd0, out_valid}, 32'd0);

    // Asynchronous reset with two beats parked in channel 2.
    out_ready = 4'h0;
    drive(1'b1, 2'd2, 1'b0, 8'h71);
    cycle();
    drive(1'b1, 2'd2, 1'b0, 8'h72);
    cycle();
    chk("ar_pre_valid", {28'd0, out_valid}, 32'b0100);
    chk("ar_pre_full", {31'd0, in_ready}, 32'd0);
    chk("ar_pre_drop3", {30'd0, drop_cnt3}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", {28'd0, out_valid}, 32'd0);
    chk("ar_out_data", out_data, 32'd0);
    chk("ar_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    chk("ar_drop_cnt3", {30'd0, drop_cnt3}, 32'd0);
    chk("ar_in_ready", {31'd0, in_ready}, 32'd0);
    drive(1'b0, 2'd0, 1'b0, 8'h00);
    cycle();
    #2;
    rst_n = 1'b1;
    cycle();
    chk("ar_post_valid", {28'd0, out_valid}, 32'd0);
    chk("ar_post_in_ready", {31'd0, in_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Parametrised, registered 1-to-NUM_CH stream demultiplexer; successor to the combinational 2-bit-select demux.
- Routes each accepted input beat to the channel chosen by in_sel, or to all channels in broadcast mode.
- Valid/ready handshakes on both sides and a 2-entry FIFO per output channel.
- Sits between a single producer and NUM_CH independent consumers.

Parameters:
- DATA_W, 8, payload width in bits.
- NUM_CH, 4, number of output channels; legal range 2 to 2**SEL_W.
- SEL_W, 2, select width.
- CNT_W, 8, width of the drop counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  producer has a beat.
- in_ready  output  1  block accepts the beat this cycle.
- in_sel  input  SEL_W  destination channel index.
- in_bcast  input  1  1 = deliver beat to every channel; in_sel ignored.
- in_data  input  DATA_W  payload.
- out_valid  output  NUM_CH  bit i: channel i holds a beat.
- out_ready  input  NUM_CH  bit i: consumer i takes the beat.
- out_data  output  NUM_CH*DATA_W  channel i head at [i*DATA_W +: DATA_W].
- drop_cnt  output  CNT_W  count of discarded out-of-range beats.

Behaviour:
- Reset (rst_n low, asynchronous, any time, including mid-transfer):
  - all FIFOs empty; out_valid = 0, out_data = 0, drop_cnt = 0.
  - in_ready = 0 while rst_n is low.
  - Beats in flight are lost.
- Input accept: on a rising edge where in_valid & in_ready = 1.
- in_ready rules (combinational from in_sel, in_bcast and FIFO occupancy only; never from out_ready):
  - broadcast: 1 iff no channel FIFO is full.
  - unicast, in_sel < NUM_CH: 1 iff FIFO[in_sel] is not full.
  - unicast, in_sel >= NUM_CH: always 1; the beat is discarded.
- Output handshake: channel i pops when out_valid[i] & out_ready[i] = 1.
  - out_valid[i] = FIFO[i] non-empty; out_data slice i = FIFO[i] head.
  - The slice is held stable while out_valid[i] = 1 and out_ready[i] = 0.
  - Slice value when empty is don't-care; the bench checks only when valid.
- Latency: a beat accepted at edge k gives out_valid = 1 in the cycle following edge k. There is no combinational in-to-out path.
- Per-channel FIFO:
  - depth 2, occupancy 0..2.
  - Push and pop on the same edge: occupancy unchanged, order preserved.
  - Full means occupancy 2, so push is blocked by in_ready; there is no pass-through when full.
  - Sustained 1 beat/cycle per channel when its consumer holds out_ready = 1.
- Broadcast: one accept pushes the same in_data into every FIFO on the same edge. Channels then drain independently.
- Ordering: per-channel FIFO order is preserved. There is no ordering guarantee across channels.
- drop_cnt:
  - increments by 1 on each accepted unicast beat with in_sel >= NUM_CH.
  - saturates at 2**CNT_W-1.
  - never wraps; cleared only by reset.
- Idle: in_valid = 0 leaves FIFO occupancy, aside from pops, and drop_cnt unchanged.

Test Plan:
1. Reset check. Assert rst_n = 0 mid-stream with channel 2 holding 2 beats -> out_valid = 0000, drop_cnt = 0 immediately, without waiting for clk.
2. Unicast sweep with all out_ready = 1. For i = 0..3, send in_sel = i, in_data = 8'hA0+i -> out_valid = one-hot(i) one cycle later, slice i = A0+i, other bits 0, in_ready stays 1.
3. Backpressure. Hold out_ready[1] = 0; send 3 beats 11, 22, 33 to channel 1 -> first two accepted, in_ready = 0 on the third. Release out_ready[1] -> outputs 11 then 22, then 33 is accepted.
4. Broadcast. Send in_bcast = 1, data 5A, with channel 3 FIFO full -> in_ready = 0. After channel 3 pops -> beat accepted and every channel outputs 5A on the next cycle.
5. Out-of-range drop. With NUM_CH = 3, SEL_W = 2, CNT_W = 2, send 5 beats with in_sel = 3 -> all accepted, no out_valid asserted, drop_cnt goes 1, 2, 3, 3, 3.
6. Throughput and ordering. Stream 16 beats to channel 0 with out_ready[0] = 1 -> in_ready stays 1 throughout, outputs appear in order, 1 beat/cycle, latency 1.
